dtu_param: RTL and testbench
============================

Name: dtu_param

Overview:
- Parametrised single-clock successor of the dtu transceiver: one async-serial TX and one RX engine sharing a clock.
- Generalised in character width, parity mode, stop-bit count and baud divisor.
- Adds RX start-bit validation, parity/framing/overrun flags, and an internal loopback mode.
- Sits between the character source/sink logic and the serial pins.

Parameters:
- DATA_W, 7: character width in bits (5..9).
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be even, >=4.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits (1 or 2).

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; 0 forces both engines idle.
- loopback  input  1  1 = RX input taken from internal tx_line, not rx_in.
- tx_start  input  1  request transmission of tx_data.
- tx_data  input  DATA_W  character to send.
- tx_busy  output  1  TX frame in progress.
- tx_line  output  1  serial output, idle high.
- rx_in  input  1  serial input, asynchronous to clk.
- rx_ack  input  1  consumer acknowledges rx_data.
- rx_data  output  DATA_W  last received character.
- rx_busy  output  1  RX frame in progress.
- rx_ready  output  1  unacknowledged character present.
- rx_parity_err  output  1  parity mismatch on held character.
- rx_frame_err  output  1  a stop bit was sampled low.
- rx_overrun  output  1  a frame completed while rx_ready=1.

Behaviour:
- Reset values:
  - tx_line=1; all other outputs 0; rx_data=0.
  - Synchroniser flops reset to 1.
  - Both FSMs reset to IDLE.
- Frame format: start(0), DATA_W bits LSB first, parity bit if PARITY!=0, STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clks.
- Parity bit: even = XOR of data bits; odd = its inverse.
- TX FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - tx_start is sampled only in IDLE with en=1. That cycle latches tx_data.
  - tx_busy=1 and tx_line=0 from the next cycle.
  - tx_busy falls on the cycle after the last stop-bit period ends.
  - Frame length = (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT clks.
  - tx_start held high re-triggers back-to-back with one IDLE cycle between frames.
  - tx_data changes during a frame have no effect.
- RX input path: 2-flop synchroniser on the selected input (rx_in, or tx_line when loopback=1).
- RX FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: a synchronised 1->0 transition enters START; rx_busy=1.
  - START: wait CLKS_PER_BIT/2 clks and resample. If high, it is a false start: return to IDLE, no flags.
  - Remaining bits are sampled every CLKS_PER_BIT clks, i.e. at bit centres.
  - All STOP_BITS stop bits are sampled. Any low sets frame error, but all stop periods still elapse.
- RX completion cycle (last stop-bit sample):
  - rx_busy=0.
  - If rx_ready=0, or rx_ack=1 in the same cycle: rx_data, rx_parity_err and rx_frame_err are updated, and rx_ready=1.
  - If rx_ready=1 and rx_ack=0: new character discarded; rx_data and error flags unchanged; rx_overrun=1.
- rx_ack:
  - Clears rx_ready, rx_parity_err, rx_frame_err and rx_overrun on the next cycle, unless a completion lands in the same cycle (rule above; rx_overrun still clears).
  - rx_ack with rx_ready=0 is ignored.
- en=0 (synchronous):
  - Both FSMs go to IDLE; tx_line=1; busy flags 0; baud counters cleared.
  - rx_ready, rx_data and the error flags are held.
- Reset mid-frame: immediate return to reset values. tx_line goes high asynchronously.
- Loopback: tx_line still drives the pin while rx_in is ignored.

Test Plan:
- Basic TX, DATA_W=7, CLKS_PER_BIT=4, PARITY=1, STOP_BITS=1: tx_start one cycle with tx_data=7'h41.
  - tx_line emits 0,1,0,0,0,0,0,1, parity 0, stop 1, each bit 4 clks.
  - tx_busy high exactly 40 clks.
- Loopback, same configuration: send 7'h55.
  - rx_ready rises within 2 synchroniser clks of the last stop sample.
  - rx_data=7'h55, rx_parity_err=0, rx_frame_err=0.
  - rx_ack pulse clears rx_ready next cycle.
- Error injection on rx_in, loopback=0:
  - Frame 7'h41 with parity bit 1 -> rx_parity_err=1.
  - Frame with stop bit 0 -> rx_frame_err=1, rx_ready=1.
- Overrun: receive 7'h11, then 7'h22 without rx_ack -> rx_data stays 7'h11, rx_overrun=1.
  - Repeat with rx_ack coinciding with the second completion -> rx_data=7'h22, rx_overrun=0.
- Glitch and enable: 1-clk low pulse on rx_in -> rx_busy pulses, then returns 0 with no rx_ready.
  - en=0 mid-TX -> tx_line=1 and tx_busy=0 next cycle.
- Config sweep: DATA_W=8, PARITY=2, STOP_BITS=2, CLKS_PER_BIT=6, loopback 8'hA5.
  - Odd parity bit 1; frame length 72 clks; rx_data=8'hA5, no error flags.

Source files
------------

// File: rtl/dtu_param_if.sv
//------------------------------------------------------------------------------
// Module   : dtu_param_if
// Purpose  : Bundles the character-side and serial-side signals of dtu_param.
//            The slave modport is the transceiver; the master modport is the
//            character source/sink (or a testbench).
// Signals  : en, loopback               - block enable, internal loopback
//            tx_start, tx_data          - transmit request and character
//            tx_busy, tx_line           - transmit status, serial output
//            rx_in, rx_ack              - serial input, receive acknowledge
//            rx_data, rx_busy, rx_ready - received character and status
//            rx_parity_err, rx_frame_err, rx_overrun - receive error flags
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dtu_param_if #(
  parameter int DATA_W = 7
) ();
  logic              en;
  logic              loopback;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              tx_line;
  logic              rx_in;
  logic              rx_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_busy;
  logic              rx_ready;
  logic              rx_parity_err;
  logic              rx_frame_err;
  logic              rx_overrun;

  modport master (
    output en, loopback, tx_start, tx_data, rx_in, rx_ack,
    input  tx_busy, tx_line, rx_data, rx_busy, rx_ready,
           rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  en, loopback, tx_start, tx_data, rx_in, rx_ack,
    output tx_busy, tx_line, rx_data, rx_busy, rx_ready,
           rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

`default_nettype wire

// File: rtl/dtu_param.sv
//------------------------------------------------------------------------------
// Module   : dtu_param
// Purpose  : Parametrised async-serial transceiver (one TX, one RX engine) on
//            a single clock. Configurable character width, parity, stop bits
//            and bit period; RX start-bit validation, parity/framing/overrun
//            flags and an internal TX->RX loopback.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - dtu_param_if.slave (character and serial signals)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dtu_param #(
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  dtu_param_if.slave  bus
);

  localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
  localparam int                 c_bit_w    = $clog2(DATA_W);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_W - 1);
  localparam logic               c_has_par  = (PARITY != 0);
  localparam logic               c_odd      = (PARITY == 2);
  localparam logic               c_stop_last = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- TX ----
  state_t              r_tx_state, w_tx_state_nxt;
  logic [c_cnt_w-1:0]  r_tx_cnt, w_tx_cnt_nxt;
  logic [c_bit_w-1:0]  r_tx_bit, w_tx_bit_nxt;
  logic                r_tx_stop, w_tx_stop_nxt;
  logic [DATA_W-1:0]   r_tx_shift, w_tx_shift_nxt;
  logic                r_tx_par, w_tx_par_nxt;
  logic                r_tx_line, w_tx_line_nxt;
  logic                w_tx_tick;

  assign w_tx_tick = (r_tx_cnt == c_cnt_last);

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_stop_nxt  = r_tx_stop;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_par_nxt   = r_tx_par;
    if (!bus.en) begin
      w_tx_state_nxt = S_IDLE;
      w_tx_cnt_nxt   = '0;
      w_tx_bit_nxt   = '0;
      w_tx_stop_nxt  = 1'b0;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (bus.tx_start) begin
            w_tx_state_nxt = S_START;
            w_tx_cnt_nxt   = '0;
            w_tx_shift_nxt = bus.tx_data;
            w_tx_par_nxt   = (^bus.tx_data) ^ c_odd;
          end
        end
        default: begin
          w_tx_cnt_nxt = w_tx_tick ? '0 : r_tx_cnt + 1'b1;
          if (w_tx_tick) begin
            case (r_tx_state)
              S_START: begin
                w_tx_state_nxt = S_DATA;
                w_tx_bit_nxt   = '0;
              end
              S_DATA: begin
                w_tx_shift_nxt = r_tx_shift >> 1;
                w_tx_bit_nxt   = r_tx_bit + 1'b1;
                if (r_tx_bit == c_bit_last) begin
                  w_tx_state_nxt = c_has_par ? S_PARITY : S_STOP;
                  w_tx_stop_nxt  = 1'b0;
                end
              end
              S_PARITY: begin
                w_tx_state_nxt = S_STOP;
                w_tx_stop_nxt  = 1'b0;
              end
              S_STOP: begin
                if (r_tx_stop == c_stop_last) w_tx_state_nxt = S_IDLE;
                else                          w_tx_stop_nxt  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
    // Line level is registered from the next state so the pin never glitches.
    case (w_tx_state_nxt)
      S_START:  w_tx_line_nxt = 1'b0;
      S_DATA:   w_tx_line_nxt = w_tx_shift_nxt[0];
      S_PARITY: w_tx_line_nxt = r_tx_par;
      default:  w_tx_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_stop  <= w_tx_stop_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_par   <= w_tx_par_nxt;
      r_tx_line  <= w_tx_line_nxt;
    end
  end

  assign bus.tx_busy = (r_tx_state != S_IDLE);
  assign bus.tx_line = r_tx_line;

  // ---------------------------------------------------------------- RX ----
  logic                w_rx_sel;
  logic                r_sync1, r_sync2, r_sync3;
  logic                w_rx_fall;
  state_t              r_rx_state, w_rx_state_nxt;
  logic [c_cnt_w-1:0]  r_rx_cnt, w_rx_cnt_nxt;
  logic [c_bit_w-1:0]  r_rx_bit, w_rx_bit_nxt;
  logic                r_rx_stop, w_rx_stop_nxt;
  logic [DATA_W-1:0]   r_rx_shift, w_rx_shift_nxt;
  logic                r_rx_par_bit, w_rx_par_bit_nxt;
  logic                r_rx_ferr_acc, w_rx_ferr_acc_nxt;
  logic                w_rx_done, w_rx_tick, w_rx_perr;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_ready, r_rx_perr, r_rx_ferr, r_rx_ovr;

  assign w_rx_sel  = bus.loopback ? r_tx_line : bus.rx_in;
  // r_sync3 is only a history flop for edge detection, not a sync stage.
  assign w_rx_fall = r_sync3 & ~r_sync2;
  assign w_rx_tick = (r_rx_cnt == c_cnt_last);
  assign w_rx_perr = c_has_par & (r_rx_par_bit != ((^r_rx_shift) ^ c_odd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= w_rx_sel;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_comb begin
    w_rx_state_nxt    = r_rx_state;
    w_rx_cnt_nxt      = r_rx_cnt;
    w_rx_bit_nxt      = r_rx_bit;
    w_rx_stop_nxt     = r_rx_stop;
    w_rx_shift_nxt    = r_rx_shift;
    w_rx_par_bit_nxt  = r_rx_par_bit;
    w_rx_ferr_acc_nxt = r_rx_ferr_acc;
    w_rx_done         = 1'b0;
    if (!bus.en) begin
      w_rx_state_nxt = S_IDLE;
      w_rx_cnt_nxt   = '0;
      w_rx_bit_nxt   = '0;
      w_rx_stop_nxt  = 1'b0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          if (w_rx_fall) begin
            w_rx_state_nxt = S_START;
            w_rx_cnt_nxt   = '0;
          end
        end
        S_START: begin
          // Half a bit in: still low means a real start bit, and from here
          // every full bit period lands on a bit centre.
          if (r_rx_cnt == c_cnt_half) begin
            w_rx_cnt_nxt = '0;
            if (r_sync2) begin
              w_rx_state_nxt = S_IDLE;
            end else begin
              w_rx_state_nxt    = S_DATA;
              w_rx_bit_nxt      = '0;
              w_rx_ferr_acc_nxt = 1'b0;
            end
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 1'b1;
          end
        end
        default: begin
          w_rx_cnt_nxt = w_rx_tick ? '0 : r_rx_cnt + 1'b1;
          if (w_rx_tick) begin
            case (r_rx_state)
              S_DATA: begin
                w_rx_shift_nxt = {r_sync2, r_rx_shift[DATA_W-1:1]};
                w_rx_bit_nxt   = r_rx_bit + 1'b1;
                if (r_rx_bit == c_bit_last) begin
                  w_rx_state_nxt = c_has_par ? S_PARITY : S_STOP;
                  w_rx_stop_nxt  = 1'b0;
                end
              end
              S_PARITY: begin
                w_rx_par_bit_nxt = r_sync2;
                w_rx_state_nxt   = S_STOP;
                w_rx_stop_nxt    = 1'b0;
              end
              S_STOP: begin
                if (!r_sync2) w_rx_ferr_acc_nxt = 1'b1;
                if (r_rx_stop == c_stop_last) begin
                  w_rx_state_nxt = S_IDLE;
                  w_rx_done      = 1'b1;
                end else begin
                  w_rx_stop_nxt = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state    <= S_IDLE;
      r_rx_cnt      <= '0;
      r_rx_bit      <= '0;
      r_rx_stop     <= 1'b0;
      r_rx_shift    <= '0;
      r_rx_par_bit  <= 1'b0;
      r_rx_ferr_acc <= 1'b0;
      r_rx_data     <= '0;
      r_rx_ready    <= 1'b0;
      r_rx_perr     <= 1'b0;
      r_rx_ferr     <= 1'b0;
      r_rx_ovr      <= 1'b0;
    end else begin
      r_rx_state    <= w_rx_state_nxt;
      r_rx_cnt      <= w_rx_cnt_nxt;
      r_rx_bit      <= w_rx_bit_nxt;
      r_rx_stop     <= w_rx_stop_nxt;
      r_rx_shift    <= w_rx_shift_nxt;
      r_rx_par_bit  <= w_rx_par_bit_nxt;
      r_rx_ferr_acc <= w_rx_ferr_acc_nxt;
      if (w_rx_done) begin
        // A same-cycle ack frees the holding slot for the new character.
        if (!r_rx_ready || bus.rx_ack) begin
          r_rx_data  <= r_rx_shift;
          r_rx_perr  <= w_rx_perr;
          r_rx_ferr  <= w_rx_ferr_acc_nxt;
          r_rx_ready <= 1'b1;
          r_rx_ovr   <= 1'b0;
        end else begin
          r_rx_ovr <= 1'b1;
        end
      end else if (bus.en && bus.rx_ack && r_rx_ready) begin
        r_rx_ready <= 1'b0;
        r_rx_perr  <= 1'b0;
        r_rx_ferr  <= 1'b0;
        r_rx_ovr   <= 1'b0;
      end
    end
  end

  assign bus.rx_busy       = (r_rx_state != S_IDLE);
  assign bus.rx_data       = r_rx_data;
  assign bus.rx_ready      = r_rx_ready;
  assign bus.rx_parity_err = r_rx_perr;
  assign bus.rx_frame_err  = r_rx_ferr;
  assign bus.rx_overrun    = r_rx_ovr;

endmodule

`default_nettype wire

// File: tb/tb_dtu_param.sv
//------------------------------------------------------------------------------
// Module   : tb_dtu_param
// Purpose  : Scoreboard testbench for dtu_param. Two instances: A (7 bits,
//            4 clk/bit, even parity, 1 stop) and B (8 bits, 6 clk/bit, odd
//            parity, 2 stop). Expected TX frames and RX characters are queued
//            when stimulus is issued; monitors pop and compare on DUT output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dtu_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dtu_param_if #(.DATA_W(7)) bus_a ();
  dtu_param_if #(.DATA_W(8)) bus_b ();

  dtu_param #(.DATA_W(7), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  dtu_param #(.DATA_W(8), .CLKS_PER_BIT(6), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;

  logic        sel = 1'b0;        // 0 = instance A observed, 1 = instance B
  logic        tx_mon_on = 1'b1;
  logic [15:0] tx_exp_bits[$];    // bit 0 = start bit, LSB-first frame image
  int          tx_exp_len[$];
  logic [10:0] rx_exp[$];         // {parity_err, frame_err, data[8:0]}

  logic       m_busy, m_line, m_ready, m_perr, m_ferr;
  logic [8:0] m_data;
  int         m_cpb;

  always_comb begin
    if (sel) begin
      m_busy = bus_b.tx_busy;  m_line = bus_b.tx_line;  m_ready = bus_b.rx_ready;
      m_perr = bus_b.rx_parity_err;  m_ferr = bus_b.rx_frame_err;
      m_data = 9'(bus_b.rx_data);  m_cpb = 6;
    end else begin
      m_busy = bus_a.tx_busy;  m_line = bus_a.tx_line;  m_ready = bus_a.rx_ready;
      m_perr = bus_a.rx_parity_err;  m_ferr = bus_a.rx_frame_err;
      m_data = 9'(bus_a.rx_data);  m_cpb = 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // TX monitor: samples tx_line at every bit centre while tx_busy is high.
  initial begin : tx_mon
    logic prev;
    logic [15:0] bits;
    int n;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_mon_on && m_busy && !prev) begin
        bits = '0;
        n = 0;
        while (m_busy && n < 200) begin
          if ((n % m_cpb) == (m_cpb / 2) && (n / m_cpb) < 16) bits[n / m_cpb] = m_line;
          n++;
          @(negedge clk);
        end
        check("tx_frame_expected", 32'(tx_exp_len.size() != 0), 1);
        if (tx_exp_len.size() != 0) begin
          check("tx_frame_bits", 32'(bits), 32'(tx_exp_bits.pop_front()));
          check("tx_busy_len", n, tx_exp_len.pop_front());
        end
      end
      prev = m_busy;
    end
  end

  // RX monitor: compares each new character on the rising edge of rx_ready.
  initial begin : rx_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (m_ready && !prev) begin
        check("rx_char_expected", 32'(rx_exp.size() != 0), 1);
        if (rx_exp.size() != 0) check("rx_char", {m_perr, m_ferr, m_data}, 32'(rx_exp.pop_front()));
      end
      prev = m_ready;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_tx_idle();
    int n = 0;
    while (m_busy && n < 500) begin @(negedge clk); n++; end
    check("tx_idle_timeout", 32'(m_busy), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ready(input int limit, output int lat);
    lat = 0;
    while (!m_ready && lat < limit) begin @(negedge clk); lat++; end
    check("rx_ready_timeout", 32'(m_ready), 1);
  endtask

  task automatic ack_a();
    bus_a.rx_ack = 1'b1;
    @(negedge clk);
    bus_a.rx_ack = 1'b0;
  endtask

  // Drives one frame on A's rx_in (4 clk/bit); returns on the negedge just
  // before the edge that samples the stop bit.
  task automatic send_a(input logic [6:0] d, input logic par, input logic stop);
    logic [9:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus_a.rx_in = f[i];
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic start_tx_a(input logic [6:0] d);
    bus_a.tx_data  = d;
    bus_a.tx_start = 1'b1;
    @(negedge clk);
    bus_a.tx_start = 1'b0;
  endtask

  initial begin : stim
    int lat;
    bus_a.en = 1'b1; bus_a.loopback = 1'b0; bus_a.tx_start = 1'b0; bus_a.tx_data = '0;
    bus_a.rx_in = 1'b1; bus_a.rx_ack = 1'b0;
    bus_b.en = 1'b1; bus_b.loopback = 1'b0; bus_b.tx_start = 1'b0; bus_b.tx_data = '0;
    bus_b.rx_in = 1'b1; bus_b.rx_ack = 1'b0;

    #2 rst_n = 1'b0;
    #6;
    check("reset_a", {bus_a.tx_line, bus_a.tx_busy, bus_a.rx_busy, bus_a.rx_ready,
                      bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_overrun, bus_a.rx_data},
          {1'b1, 6'b0, 7'h00});
    check("reset_b", {bus_b.tx_line, bus_b.tx_busy, bus_b.rx_busy, bus_b.rx_ready,
                      bus_b.rx_parity_err, bus_b.rx_frame_err, bus_b.rx_overrun, bus_b.rx_data},
          {1'b1, 6'b0, 8'h00});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic TX 7'h41: start,1,0,0,0,0,0,1,parity 0,stop 1; busy 40 clks.
    tx_exp_bits.push_back(16'h0282); tx_exp_len.push_back(40);
    start_tx_a(7'h41);
    repeat (8) @(negedge clk);
    bus_a.tx_data = 7'h7F;          // must not disturb the frame in flight
    wait_tx_idle();

    // Loopback 7'h55 (four ones, even parity 0).
    bus_a.loopback = 1'b1;
    tx_exp_bits.push_back(16'h02AA); tx_exp_len.push_back(40);
    rx_exp.push_back({1'b0, 1'b0, 9'h055});
    start_tx_a(7'h55);
    wait_ready(100, lat);
    // Stop centre at clk 38 of the frame plus synchroniser/edge latency.
    check("loopback_latency_in_window", 32'(lat >= 40 && lat <= 43), 1);
    wait_tx_idle();
    ack_a();
    check("ack_clears_ready", 32'(bus_a.rx_ready), 0);
    bus_a.loopback = 1'b0;
    repeat (4) @(negedge clk);

    // Parity error: 7'h41 has even parity 0; send 1.
    rx_exp.push_back({1'b1, 1'b0, 9'h041});
    send_a(7'h41, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    ack_a();
    // Frame error: 7'h33 (four ones, parity 0) with stop bit low.
    rx_exp.push_back({1'b0, 1'b1, 9'h033});
    send_a(7'h33, 1'b0, 1'b0);
    bus_a.rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("frame_err_ready", {bus_a.rx_ready, bus_a.rx_frame_err}, 2'b11);
    ack_a();
    check("ack_clears_flags", {bus_a.rx_ready, bus_a.rx_parity_err, bus_a.rx_frame_err}, 3'b000);
    repeat (4) @(negedge clk);

    // Overrun: 7'h11 then 7'h22 without ack (both have parity 0).
    rx_exp.push_back({1'b0, 1'b0, 9'h011});
    send_a(7'h11, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    send_a(7'h22, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("overrun_hold", {bus_a.rx_ready, bus_a.rx_overrun, bus_a.rx_data}, {2'b11, 7'h11});
    ack_a();
    check("overrun_ack_clear", {bus_a.rx_ready, bus_a.rx_overrun}, 2'b00);
    repeat (4) @(negedge clk);
    // Same again, but ack lands on the second completion cycle.
    rx_exp.push_back({1'b0, 1'b0, 9'h011});
    send_a(7'h11, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    send_a(7'h22, 1'b0, 1'b1);
    ack_a();
    check("ack_on_completion", {bus_a.rx_ready, bus_a.rx_overrun, bus_a.rx_parity_err,
                                bus_a.rx_frame_err, bus_a.rx_data}, {4'b1000, 7'h22});
    ack_a();
    repeat (4) @(negedge clk);

    // Glitch: one-clock low pulse is a false start.
    bus_a.rx_in = 1'b0;
    @(negedge clk);
    bus_a.rx_in = 1'b1;
    lat = 0;
    while (!bus_a.rx_busy && lat < 6) begin @(negedge clk); lat++; end
    check("glitch_busy_rise", 32'(bus_a.rx_busy), 1);
    lat = 0;
    while (bus_a.rx_busy && lat < 10) begin @(negedge clk); lat++; end
    check("glitch_busy_fall", 32'(bus_a.rx_busy), 0);
    repeat (6) @(negedge clk);
    check("glitch_no_ready", {bus_a.rx_ready, bus_a.rx_frame_err, bus_a.rx_parity_err}, 3'b000);

    // en=0 mid-frame forces TX idle on the next cycle.
    tx_mon_on = 1'b0;
    start_tx_a(7'h00);
    repeat (10) @(negedge clk);
    bus_a.en = 1'b0;
    @(negedge clk);
    check("en_off_tx", {bus_a.tx_line, bus_a.tx_busy}, 2'b10);
    bus_a.en = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-frame: line must rise before any clock edge.
    start_tx_a(7'h00);
    repeat (12) @(negedge clk);
    check("pre_reset_line_low", 32'(bus_a.tx_line), 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_tx", {bus_a.tx_line, bus_a.tx_busy}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_mon_on = 1'b1;

    // Config B loopback 8'hA5: odd parity 1, two stops, 72 clks.
    sel = 1'b1;
    @(negedge clk);
    bus_b.loopback = 1'b1;
    tx_exp_bits.push_back(16'h0F4A); tx_exp_len.push_back(72);
    rx_exp.push_back({1'b0, 1'b0, 9'h0A5});
    bus_b.tx_data  = 8'hA5;
    bus_b.tx_start = 1'b1;
    @(negedge clk);
    bus_b.tx_start = 1'b0;
    wait_ready(200, lat);
    wait_tx_idle();
    check("cfg_b_flags", {bus_b.rx_parity_err, bus_b.rx_frame_err, bus_b.rx_overrun}, 3'b000);

    repeat (4) @(negedge clk);
    check("tx_queue_drained", tx_exp_len.size(), 0);
    check("rx_queue_drained", rx_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
